// File: rtl/rpn_token_sequencer.sv
// Byte-stream controller feeding a digit-accumulating parser and emitting RPN number/operator tokens.
// Optional macro DIV_OP_EN makes '/' an operator (code 3); otherwise '/' is an illegal character.
module rpn_token_sequencer #(
    parameter int MAX_DIGITS    = 5,
    parameter int READY_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [3:0]  o_dig,
    output logic        o_dig_wen,
    output logic        o_dig_flush,
    input  logic        i_dig_ready,
    input  logic [15:0] i_dig_dout,
    output logic        o_tok_valid,
    output logic        o_tok_is_op,
    output logic [1:0]  o_tok_op,
    output logic [15:0] o_tok_value,
    input  logic        i_tok_ready,
    output logic        o_err,
    output logic [2:0]  o_state_dbg
);
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int TW = $clog2(READY_TIMEOUT + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_DIGITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(READY_TIMEOUT - 1);
`ifdef DIV_OP_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FLUSH, S_WAIT, S_EMIT_NUM, S_EMIT_OP, S_ERR
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [TW-1:0]   r_timer, w_timer_next;
    logic            r_pend, w_pend_next;
    logic [1:0]      r_op, w_op_next;
    logic [15:0]     r_tok_value, w_value_next;
    logic [3:0]      r_dig, w_dig_next;
    logic            r_rx_ready, r_dig_wen, r_dig_flush, r_tok_valid, r_tok_is_op, r_err;
    logic            w_wen_next, w_flush_next, w_err_next;
    logic            w_accept, w_is_digit, w_is_delim, w_is_op;
    logic [1:0]      w_op_code;

    assign w_accept   = i_rx_valid && r_rx_ready;
    assign w_is_digit = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);
    assign w_is_delim = (i_rx_data == 8'h20) || (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);

    always_comb begin
        w_is_op   = 1'b1;
        w_op_code = 2'd0;
        case (i_rx_data)
            8'h2B:   w_op_code = 2'd0;
            8'h2D:   w_op_code = 2'd1;
            8'h2A:   w_op_code = 2'd2;
            8'h2F: begin
                w_is_op   = DIV_EN;
                w_op_code = 2'd3;
            end
            default: w_is_op = 1'b0;
        endcase
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_timer_next = r_timer;
        w_pend_next  = r_pend;
        w_op_next    = r_op;
        w_value_next = r_tok_value;
        w_dig_next   = r_dig;
        w_wen_next   = 1'b0;
        w_flush_next = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_digit && (r_cnt < MAX_CNT)) begin
                        w_wen_next = 1'b1;
                        w_dig_next = i_rx_data[3:0];
                        w_cnt_next = r_cnt + 1'b1;
                    end else if (w_is_delim) begin
                        if (r_cnt != '0) begin
                            w_next       = S_FLUSH;
                            w_flush_next = 1'b1;
                        end
                    end else if (w_is_op) begin
                        w_op_next = w_op_code;
                        if (r_cnt != '0) begin
                            w_pend_next  = 1'b1;
                            w_next       = S_FLUSH;
                            w_flush_next = 1'b1;
                        end else begin
                            w_next = S_EMIT_OP;
                        end
                    end else begin
                        // Overflow digit or illegal byte: discard any partial number in the parser.
                        w_next       = S_ERR;
                        w_err_next   = 1'b1;
                        w_flush_next = (r_cnt != '0);
                        w_cnt_next   = '0;
                        w_pend_next  = 1'b0;
                    end
                end
            end
            S_FLUSH: begin
                w_cnt_next   = '0;
                w_timer_next = '0;
                w_next       = S_WAIT;
            end
            S_WAIT: begin
                if (i_dig_ready) begin
                    w_value_next = i_dig_dout;
                    w_next       = S_EMIT_NUM;
                end else if (r_timer == TIMER_LAST) begin
                    w_err_next  = 1'b1;
                    w_pend_next = 1'b0;
                    w_next      = S_IDLE;
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_EMIT_NUM: begin
                if (r_tok_valid && i_tok_ready) begin
                    w_pend_next = 1'b0;
                    w_next      = r_pend ? S_EMIT_OP : S_IDLE;
                end
            end
            S_EMIT_OP: begin
                if (r_tok_valid && i_tok_ready) w_next = S_IDLE;
            end
            S_ERR: begin
                if (w_accept && w_is_delim) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_timer     <= '0;
            r_pend      <= 1'b0;
            r_op        <= 2'd0;
            r_tok_value <= 16'd0;
            r_dig       <= 4'd0;
            r_rx_ready  <= 1'b0;
            r_dig_wen   <= 1'b0;
            r_dig_flush <= 1'b0;
            r_tok_valid <= 1'b0;
            r_tok_is_op <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_timer     <= w_timer_next;
            r_pend      <= w_pend_next;
            r_op        <= w_op_next;
            r_tok_value <= w_value_next;
            r_dig       <= w_dig_next;
            r_dig_wen   <= w_wen_next;
            r_dig_flush <= w_flush_next;
            r_err       <= w_err_next;
            // Handshake outputs follow the state being entered so they are valid from its first cycle.
            r_rx_ready  <= (w_next == S_IDLE) || (w_next == S_ERR);
            r_tok_valid <= (w_next == S_EMIT_NUM) || (w_next == S_EMIT_OP);
            r_tok_is_op <= (w_next == S_EMIT_OP);
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_dig       = r_dig;
    assign o_dig_wen   = r_dig_wen;
    assign o_dig_flush = r_dig_flush;
    assign o_tok_valid = r_tok_valid;
    assign o_tok_is_op = r_tok_is_op;
    assign o_tok_op    = r_op;
    assign o_tok_value = r_tok_value;
    assign o_err       = r_err;
    assign o_state_dbg = r_state;
endmodule

// File: tb/tb_rpn_token_sequencer.sv
// Directed bench for rpn_token_sequencer: table of per-byte responses, token scoreboard, parser model.
// Token transfers are checked against exp_q; define DIV_OP_EN to match the RTL build.
module tb_rpn_token_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic [3:0]  o_dig;
    logic        o_dig_wen, o_dig_flush;
    logic        i_dig_ready = 1'b0;
    logic [15:0] i_dig_dout = 16'h0;
    logic        o_tok_valid, o_tok_is_op;
    logic [1:0]  o_tok_op;
    logic [15:0] o_tok_value;
    logic        i_tok_ready = 1'b0;
    logic        o_err;
    logic [2:0]  o_state_dbg;

    int checks = 0;
    int errors = 0;
    logic [18:0] exp_q[$];

    bit          parser_en = 1'b1;
    int          parser_delay = 2;
    logic [15:0] acc, result;
    bit          busy;
    int          delay_cnt;

    rpn_token_sequencer dut (
        .clk(clk), .rst(rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_dig(o_dig), .o_dig_wen(o_dig_wen), .o_dig_flush(o_dig_flush),
        .i_dig_ready(i_dig_ready), .i_dig_dout(i_dig_dout),
        .o_tok_valid(o_tok_valid), .o_tok_is_op(o_tok_is_op), .o_tok_op(o_tok_op),
        .o_tok_value(o_tok_value), .i_tok_ready(i_tok_ready),
        .o_err(o_err), .o_state_dbg(o_state_dbg)
    );

    always #5 clk = ~clk;

    // Parser model: accumulates decimal digits, answers a flush after parser_delay cycles.
    always @(posedge clk) begin
        i_dig_ready <= 1'b0;
        if (rst) begin
            acc <= 16'd0; result <= 16'd0; busy <= 1'b0; delay_cnt <= 0;
        end else begin
            if (o_dig_wen) acc <= acc * 16'd10 + {12'd0, o_dig};
            if (o_dig_flush) begin
                busy <= 1'b1; delay_cnt <= parser_delay; result <= acc; acc <= 16'd0;
            end else if (busy) begin
                if (delay_cnt == 0) begin
                    busy <= 1'b0;
                    if (parser_en) begin
                        i_dig_ready <= 1'b1;
                        i_dig_dout  <= result;
                    end
                end else begin
                    delay_cnt <= delay_cnt - 1;
                end
            end
        end
    end

    function automatic logic [18:0] tok_key(input logic is_op, input logic [1:0] op, input logic [15:0] v);
        tok_key = {is_op, is_op ? op : 2'd0, is_op ? 16'd0 : v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every token transfer must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && o_tok_valid && i_tok_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_token actual=%0h expected=none",
                         tok_key(o_tok_is_op, o_tok_op, o_tok_value));
            end else begin
                check("token", 32'(tok_key(o_tok_is_op, o_tok_op, o_tok_value)), 32'(exp_q.pop_front()));
            end
        end
    end

    // All driver tasks start and end at #1 after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        i_rx_data = b; i_rx_valid = 1'b1;
        while (!o_rx_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!o_rx_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=rx_ready_low expected=rx_ready_high byte=%0h", b);
            i_rx_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input bit chk_no_rdy);
        int n;
        bit bad;
        n = 0; bad = 1'b0;
        while (exp_q.size() > 0 && n < 300) begin
            @(posedge clk); #1; n++;
            if (exp_q.size() > 0 && o_rx_ready) bad = 1'b1;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        if (chk_no_rdy) check("rx_ready_during_tokens", 32'(bad), 32'd0);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    typedef struct {
        logic [7:0] ch;
        logic       wen;
        logic [3:0] dig;
        logic       flush;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t tbl[10];
    int   k;
    logic [15:0] held;

    initial begin
        tbl[0] = '{8'h31, 1'b1, 4'd1, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{8'h32, 1'b1, 4'd2, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h33, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{8'h20, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h0D, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h37, 1'b1, 4'd7, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{8'h30, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{8'h0A, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{8'h78, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{8'h0A, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        check("rst_tok_valid", 32'(o_tok_valid), 32'd0);
        check("rst_strobes", 32'({o_dig_wen, o_dig_flush, o_err}), 32'd0);
        check("rst_payload", 32'({o_tok_is_op, o_tok_op, o_tok_value, o_dig}), 32'd0);
        check("rst_state", 32'(o_state_dbg), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_rx_ready", 32'(o_rx_ready), 32'd1);

        // Table: per-byte response one cycle after acceptance
        i_tok_ready = 1'b1;
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd123));
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd70));
        for (int i = 0; i < 10; i++) begin
            send_byte(tbl[i].ch);
            check($sformatf("tbl%0d", i),
                  32'({o_dig_wen, o_dig_wen ? o_dig : 4'd0, o_dig_flush, o_err, o_rx_ready}),
                  32'({tbl[i].wen, tbl[i].dig, tbl[i].flush, tbl[i].err, tbl[i].rdy}));
        end
        wait_drain(1'b0);
        check("tbl_end_idle", 32'(o_rx_ready), 32'd1);

        // "4+" with tok_ready low: number held 3 cycles, op follows with no byte accepted
        i_tok_ready = 1'b0;
        send_byte(8'h34);
        send_byte(8'h2B);
        check("4plus_flush", 32'({o_dig_flush, o_rx_ready}), 32'b10);
        k = 0;
        while (!o_tok_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("4plus_tok_valid", 32'(o_tok_valid), 32'd1);
        held = o_tok_value;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("4plus_hold%0d", i),
                  32'({o_tok_valid, o_tok_is_op, o_rx_ready, o_tok_value}), 32'({3'b100, 16'd4}));
        end
        check("4plus_stable", 32'(o_tok_value), 32'(held));
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd4));
        exp_q.push_back(tok_key(1'b1, 2'd0, 16'd0));
        i_tok_ready = 1'b1;
        wait_drain(1'b1);

        // "+" with no digits: op token directly, no flush
        i_tok_ready = 1'b0;
        send_byte(8'h2B);
        check("plus_direct", 32'({o_dig_flush, o_tok_valid, o_tok_is_op, o_tok_op, o_rx_ready}), 32'b011000);
        wait_cycles(2);
        check("plus_hold_rdy", 32'({o_tok_valid, o_rx_ready}), 32'b10);
        exp_q.push_back(tok_key(1'b1, 2'd0, 16'd0));
        i_tok_ready = 1'b1;
        wait_drain(1'b1);
        @(posedge clk); #1;
        check("plus_back_idle", 32'({o_tok_valid, o_rx_ready}), 32'b01);

        // "123456": sixth digit overflows, "7 " discarded, "8 " gives token 8
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'h30 + 8'(i));
            check($sformatf("ovf_dig%0d", i), 32'({o_dig_wen, o_dig, o_err}), 32'({1'b1, 4'(i), 1'b0}));
        end
        send_byte(8'h36);
        check("ovf_err", 32'({o_dig_wen, o_err, o_dig_flush, o_rx_ready}), 32'b0111);
        send_byte(8'h37);
        check("err_discard_7", 32'({o_dig_wen, o_err}), 32'd0);
        send_byte(8'h20);
        check("err_exit", 32'({o_dig_flush, o_err, o_rx_ready}), 32'b001);
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd8));
        send_byte(8'h38);
        send_byte(8'h20);
        wait_drain(1'b0);

        // "5 " with a silent parser: err exactly 15 cycles after WAIT entry
        parser_en = 1'b0;
        send_byte(8'h35);
        send_byte(8'h20);
        k = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (o_err) begin k = i; break; end
        end
        check("timeout_err_cycle", 32'(k), 32'd16);
        @(posedge clk); #1;
        check("timeout_err_once", 32'({o_err, o_tok_valid, o_rx_ready}), 32'b001);
        parser_en = 1'b1;
        wait_cycles(5);

        // Reset during EMIT_NUM aborts the token and clears the digit count
        i_tok_ready = 1'b0;
        send_byte(8'h36);
        send_byte(8'h20);
        k = 0;
        while (!o_tok_valid && k < 50) begin @(posedge clk); #1; k++; end
        check("rst_mid_tok_valid_before", 32'(o_tok_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_tok_valid_after", 32'({o_tok_valid, o_rx_ready}), 32'd0);
        rst = 1'b0;
        i_tok_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'h30 + 8'(i));
            check($sformatf("rst_cnt_dig%0d", i), 32'({o_dig_wen, o_err}), 32'b10);
        end
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd12345));
        send_byte(8'h20);
        wait_drain(1'b0);

        // "9/" depends on DIV_OP_EN
`ifdef DIV_OP_EN
        exp_q.push_back(tok_key(1'b0, 2'd0, 16'd9));
        exp_q.push_back(tok_key(1'b1, 2'd3, 16'd0));
        send_byte(8'h39);
        send_byte(8'h2F);
        check("div_flush", 32'({o_dig_flush, o_err}), 32'b10);
        wait_drain(1'b1);
`else
        send_byte(8'h39);
        send_byte(8'h2F);
        check("div_illegal", 32'({o_err, o_dig_flush, o_rx_ready}), 32'b111);
        send_byte(8'h20);
        wait_cycles(10);
        check("div_no_token", 32'({o_tok_valid, o_rx_ready}), 32'b01);
`endif
        wait_cycles(5);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
